// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared state encoding, pattern codes and sizing helpers for the seven-segment scan controller.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SCAN  = 2'd2
  } scan_state_t;

  localparam logic [1:0] PAT_NORMAL = 2'd0;
  localparam int         NIB_W      = 4;

  // Down-counter width able to hold max_count-1; never narrower than one bit.
  function automatic int presc_width(input int max_count);
    return ($clog2(max_count) < 1) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Host-side scan enable and display-word load handshake (load/ready) for the scan controller.
interface seven_seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  import seven_seg_pkg::*;

  logic                        en;
  logic                        load;
  logic                        ready;
  logic [NIB_W*NUM_DIGITS-1:0] value;
  logic [1:0]                  pattern;

  modport master (output en, load, value, pattern, input ready);
  modport slave  (input en, load, value, pattern, output ready);

endinterface

// File: rtl/seven_seg_prescaler.sv
// Loadable down-counter; tc is high while the count rests at zero, so reloading on tc
// yields a tick every load_val+1 cycles. clr forces the count to zero.
module seven_seg_prescaler #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt_q <= '0;
    else if (clr)            cnt_q <= '0;
    else if (load)           cnt_q <= load_val;
    else if (cnt_q != '0)    cnt_q <= cnt_q - W'(1);
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed N-digit scan with blanking dead time and a double-buffered display word.
// Optional leading-zero suppression of digit selects under `SEVEN_SEG_LZ_BLANK_EN.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seven_seg_scan_ctrl_if.slave  host,
  output logic [NIB_W-1:0]      dec_digit,
  output logic [1:0]            dec_pattern,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  frame_done
);

  localparam int W_VAL = NIB_W * NUM_DIGITS;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PW    = presc_width((REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES);
  localparam logic [PW-1:0]    SCAN_LOAD  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0]    BLANK_LOAD = PW'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

  scan_state_t           state_q, state_nxt;
  logic [IDX_W-1:0]      idx_q, idx_nxt;
  logic [NUM_DIGITS-1:0] sel_q, sel_nxt, onehot, lz_sup;
  logic [NIB_W-1:0]      dig_q, dig_nxt, nib;
  logic [1:0]            pat_q, pat_nxt;
  logic                  fd_q, fd_nxt;
  logic [W_VAL-1:0]      act_val_q, act_val_nxt, pend_val_q;
  logic [1:0]            act_pat_q, act_pat_nxt, pend_pat_q;
  logic                  pend_vld_q, ready_q;
  logic                  commit, enter_blank;
  logic                  pre_clr, pre_load, pre_tc;
  logic [PW-1:0]         pre_val;

  seven_seg_prescaler #(.W(PW)) u_presc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (pre_clr),
    .load     (pre_load),
    .load_val (pre_val),
    .tc       (pre_tc)
  );

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) onehot[i] = (idx_q == IDX_W'(i));
  end

`ifdef SEVEN_SEG_LZ_BLANK_EN
  logic zero_above;
  // Walk down from the most significant digit; digit 0 is never suppressed.
  always_comb begin
    lz_sup     = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (act_val_q[i*NIB_W +: NIB_W] == '0);
      lz_sup[i]  = zero_above & (act_pat_q == PAT_NORMAL);
    end
  end
`else
  assign lz_sup = '0;
`endif

  always_comb begin
    state_nxt   = state_q;
    idx_nxt     = idx_q;
    sel_nxt     = sel_q;
    fd_nxt      = 1'b0;
    commit      = 1'b0;
    enter_blank = 1'b0;
    pre_clr     = 1'b0;
    pre_load    = 1'b0;
    pre_val     = SCAN_LOAD;
    if (state_q == ST_IDLE) commit = pend_vld_q;
    if (!host.en) begin
      state_nxt = ST_IDLE;
      idx_nxt   = '0;
      sel_nxt   = '0;
      pre_clr   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_nxt   = ST_BLANK;
          idx_nxt     = '0;
          enter_blank = 1'b1;
        end
        ST_BLANK: if (pre_tc) begin
          state_nxt = ST_SCAN;
          pre_load  = 1'b1;
          sel_nxt   = onehot & ~lz_sup;
        end
        ST_SCAN: if (pre_tc) begin
          state_nxt   = ST_BLANK;
          sel_nxt     = '0;
          enter_blank = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_nxt = '0;
            fd_nxt  = 1'b1;
            commit  = pend_vld_q;
          end else begin
            idx_nxt = idx_q + IDX_W'(1);
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
    if (enter_blank) begin
      pre_load = 1'b1;
      pre_val  = BLANK_LOAD;
    end
  end

  assign act_val_nxt = commit ? pend_val_q : act_val_q;
  assign act_pat_nxt = commit ? pend_pat_q : act_pat_q;

  // Decoder inputs follow the word that will be active, so a frame-boundary commit shows at once.
  always_comb begin
    nib = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (idx_nxt == IDX_W'(i)) nib = act_val_nxt[i*NIB_W +: NIB_W];
    dig_nxt = dig_q;
    pat_nxt = pat_q;
    if (enter_blank) begin
      dig_nxt = nib;
      pat_nxt = act_pat_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      sel_q   <= '0;
      dig_q   <= '0;
      pat_q   <= '0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      idx_q   <= idx_nxt;
      sel_q   <= sel_nxt;
      dig_q   <= dig_nxt;
      pat_q   <= pat_nxt;
      fd_q    <= fd_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val_q <= '0;
      pend_pat_q <= '0;
      pend_vld_q <= 1'b0;
      ready_q    <= 1'b1;
      act_val_q  <= '0;
      act_pat_q  <= '0;
    end else begin
      if (host.load && ready_q) begin
        pend_val_q <= host.value;
        pend_pat_q <= host.pattern;
        pend_vld_q <= 1'b1;
        ready_q    <= 1'b0;
      end else if (commit) begin
        pend_vld_q <= 1'b0;
        ready_q    <= 1'b1;
      end
      if (commit) begin
        act_val_q <= pend_val_q;
        act_pat_q <= pend_pat_q;
      end
    end
  end

  assign host.ready  = ready_q;
  assign digit_sel   = sel_q;
  assign dec_digit   = dig_q;
  assign dec_pattern = pat_q;
  assign frame_done  = fd_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1 (20-cycle frame).
module tb_seven_seg_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] dec_digit;
  logic [1:0] dec_pattern;
  logic [3:0] digit_sel;
  logic       frame_done;
  int         n_checks;
  int         n_err;
  logic [3:0] lz_0050;
  logic [3:0] lz_0000;

  seven_seg_scan_ctrl_if #(.NUM_DIGITS(4)) host ();

  seven_seg_scan_ctrl #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .host        (host),
    .dec_digit   (dec_digit),
    .dec_pattern (dec_pattern),
    .digit_sel   (digit_sel),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one 20-cycle frame; the next edge must enter BLANK of digit 0.
  task automatic run_frame(input int fid, input logic [15:0] word, input logic [3:0] mask,
                           input logic fd0, input logic rdy0, input logic [3:0] load_at,
                           input logic [15:0] lw_first, input logic [15:0] lw_later,
                           input logic [1:0] pat);
    logic       rdy;
    logic [3:0] one;
    logic [3:0] exp_sel;
    rdy = rdy0;
    for (int d = 0; d < 4; d++) begin
      one = 4'b0001 << d;
      for (int c = 0; c < 5; c++) begin
        tick();
        if (host.load) begin
          host.load = 1'b0;
          rdy       = 1'b0;
        end
        exp_sel = (c == 0) ? 4'b0000 : (one & mask);
        chk($sformatf("f%0d d%0d c%0d digit_sel", fid, d, c), 32'(digit_sel), 32'(exp_sel));
        chk($sformatf("f%0d d%0d c%0d dec_digit", fid, d, c), 32'(dec_digit), 32'(word[d*4 +: 4]));
        chk($sformatf("f%0d d%0d c%0d dec_pattern", fid, d, c), 32'(dec_pattern), 32'(pat));
        chk($sformatf("f%0d d%0d c%0d frame_done", fid, d, c), 32'(frame_done),
            32'((d == 0 && c == 0) ? fd0 : 1'b0));
        chk($sformatf("f%0d d%0d c%0d ready", fid, d, c), 32'(host.ready), 32'(rdy));
        if (c == 0 && load_at[d]) begin
          host.load  = 1'b1;
          host.value = (d == 0) ? lw_first : lw_later;
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
`ifdef SEVEN_SEG_LZ_BLANK_EN
    lz_0050 = 4'b0011;
    lz_0000 = 4'b0001;
`else
    lz_0050 = 4'b1111;
    lz_0000 = 4'b1111;
`endif
    rst_n        = 1'b0;
    host.en      = 1'b0;
    host.load    = 1'b0;
    host.value   = 16'h0000;
    host.pattern = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset digit_sel", 32'(digit_sel), 32'h0);
    chk("reset dec_digit", 32'(dec_digit), 32'h0);
    chk("reset dec_pattern", 32'(dec_pattern), 32'h0);
    chk("reset ready", 32'(host.ready), 32'h1);
    chk("reset frame_done", 32'(frame_done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Load 4321 while idle: commits the cycle after acceptance.
    host.load  = 1'b1;
    host.value = 16'h4321;
    tick();
    host.load = 1'b0;
    chk("idle load ready low", 32'(host.ready), 32'h0);
    tick();
    chk("idle commit ready high", 32'(host.ready), 32'h1);
    chk("idle digit_sel", 32'(digit_sel), 32'h0);
    host.en = 1'b1;

    run_frame(1, 16'h4321, 4'hF, 1'b0, 1'b1, 4'b0000, 16'h0, 16'h0, 2'd0);
    // Mid-frame load of 9876, then FFFF while ready is low (dropped).
    run_frame(2, 16'h4321, 4'hF, 1'b1, 1'b1, 4'b0101, 16'h9876, 16'hFFFF, 2'd0);
    run_frame(3, 16'h9876, 4'hF, 1'b1, 1'b1, 4'b0000, 16'h0, 16'h0, 2'd0);

    // Drop en in the second SCAN cycle of digit 2.
    repeat (13) tick();
    chk("pre-drop digit_sel", 32'(digit_sel), 32'h4);
    chk("pre-drop dec_digit", 32'(dec_digit), 32'h8);
    host.en = 1'b0;
    tick();
    chk("en drop digit_sel", 32'(digit_sel), 32'h0);
    chk("en drop dec_digit hold", 32'(dec_digit), 32'h8);
    chk("en drop frame_done", 32'(frame_done), 32'h0);
    tick();
    chk("idle digit_sel", 32'(digit_sel), 32'h0);
    host.en = 1'b1;
    run_frame(4, 16'h9876, 4'hF, 1'b0, 1'b1, 4'b0000, 16'h0, 16'h0, 2'd0);

    // Leading-zero word with pattern 0, then the same word with pattern 1.
    run_frame(5, 16'h9876, 4'hF, 1'b1, 1'b1, 4'b0001, 16'h0050, 16'h0, 2'd0);
    host.pattern = 2'd1;
    run_frame(6, 16'h0050, lz_0050, 1'b1, 1'b1, 4'b0001, 16'h0050, 16'h0, 2'd0);
    run_frame(7, 16'h0050, 4'hF, 1'b1, 1'b1, 4'b0000, 16'h0, 16'h0, 2'd1);

    // Reset in the middle of SCAN with a word pending.
    tick();
    chk("f8 boundary frame_done", 32'(frame_done), 32'h1);
    tick();
    host.load    = 1'b1;
    host.value   = 16'h1234;
    host.pattern = 2'd0;
    tick();
    host.load = 1'b0;
    chk("pre-reset ready", 32'(host.ready), 32'h0);
    chk("pre-reset digit_sel", 32'(digit_sel), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset digit_sel", 32'(digit_sel), 32'h0);
    chk("async reset ready", 32'(host.ready), 32'h1);
    chk("async reset dec_digit", 32'(dec_digit), 32'h0);
    chk("async reset dec_pattern", 32'(dec_pattern), 32'h0);
    chk("async reset frame_done", 32'(frame_done), 32'h0);
    host.en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post-reset digit_sel", 32'(digit_sel), 32'h0);
    host.en = 1'b1;
    run_frame(9, 16'h0000, lz_0000, 1'b0, 1'b1, 4'b0000, 16'h0, 16'h0, 2'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
